// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an async serial transmitter (LSB first, idle-high).
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); default build sends 8N1.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_we,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int              DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [15:0]     DIV_LAST = 16'(DIV - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [15:0]   div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign head    = mem[rd_ptr];
  assign bit_end = (div_cnt == '0);
  assign push    = din_we && !full;
  // A frame pops the head either from idle or at the last cycle of its stop bit.
  assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // NOTE: the storage array has no reset; pointers and count alone say which slots are valid.
  always_ff @(posedge clk_sys) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      full     <= (count_next == DEPTH_C);
      empty    <= (count_next == '0);
      overflow <= din_we && full;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      if (state != IDLE)
        div_cnt <= bit_end ? DIV_LAST : div_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= head;
`ifdef UART_TX_PARITY_EN
            parity  <= ^head;
`endif
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= DIV_LAST;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              // shift[1] is the next bit because the shift lands on this same edge.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift  <= head;
`ifdef UART_TX_PARITY_EN
              parity <= ^head;
`endif
              state  <= START;
              tx     <= 1'b0;
            end else begin
              state  <= IDLE;
              busy   <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes frames into a queue and
// test sequences compare them against expected bytes, timings and flag behaviour.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * DIV;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] din     = 8'h00;
  logic       din_we  = 1'b0;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       tx;

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .din      (din),
    .din_we   (din_we),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc     = 0;
  int ovf_cnt = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         start;
    bit         glitch;
    bit         aborted;
  } rx_rec_t;

  rx_rec_t rx_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: every bit slot must hold one level for exactly DIV cycles.
  initial begin : monitor
    rx_rec_t               r;
    logic [FRAME_BITS-1:0] smp;
    logic                  first;
    forever begin
      @(negedge clk_sys);
      if (!reset && tx === 1'b0) begin
        r.start   = cyc;
        r.glitch  = 1'b0;
        r.aborted = 1'b0;
        first     = 1'b0;
        smp       = '0;
        for (int k = 0; k < FRAME_BITS; k++) begin
          for (int c = 0; c < DIV; c++) begin
            if (k > 0 || c > 0) @(negedge clk_sys);
            if (reset) r.aborted = 1'b1;
            if (c == 0) first = tx;
            else if (tx !== first) r.glitch = 1'b1;
            if (c == DIV / 2) smp[k] = tx;
          end
        end
        r.data = smp[8:1];
        r.par  = smp[9];
        r.stop = smp[FRAME_BITS-1];
        if (smp[0] !== 1'b0) r.glitch = 1'b1;
        rx_q.push_back(r);
      end
    end
  end

  task automatic get_frame(input string name, input logic [7:0] exp_data, input logic exp_par,
                           output int start);
    int      waited;
    rx_rec_t r;
    waited = 0;
    start  = -1;
    while (rx_q.size() == 0 && waited < 3 * FRAME_CYC) begin
      @(negedge clk_sys);
      waited++;
    end
    if (rx_q.size() == 0) begin
      check({name, " frame_timeout"}, 32'(waited), 32'(3 * FRAME_CYC + 1));
    end else begin
      r     = rx_q.pop_front();
      start = r.start;
      check({name, " data"}, {24'h0, r.data}, {24'h0, exp_data});
      check({name, " shape(aborted,glitch,stop)"}, {29'h0, r.aborted, r.glitch, r.stop}, 32'h1);
`ifdef UART_TX_PARITY_EN
      check({name, " parity"}, {31'h0, r.par}, {31'h0, exp_par});
`else
      if (exp_par !== 1'b0 && exp_par !== 1'b1) check({name, " par_known"}, 32'h0, 32'h1);
`endif
    end
  endtask

  task automatic write_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(posedge clk_sys); #1;
      din    = b[i];
      din_we = 1'b1;
    end
    @(posedge clk_sys); #1;
    din_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk_sys);
    while ((busy !== 1'b0 || empty !== 1'b1) && n < 8 * FRAME_CYC) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, " reaches_idle"}, {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk_sys);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t       vecs[8];
    logic [7:0] q[$];
    logic [7:0] model[$];
    logic [7:0] ov_bytes[6];
    int         s0;
    int         s1;
    int         n;
    int         ovf0;
    int         lows;
    rx_rec_t    r;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'hA5, 1'b0};
    vecs[6] = '{8'h07, 1'b1};
    vecs[7] = '{8'h03, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset tx", {31'h0, tx}, 32'h1);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset full", {31'h0, full}, 32'h0);
    check("reset empty", {31'h0, empty}, 32'h1);
    check("reset overflow", {31'h0, overflow}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Single byte: one-cycle latency, then busy for exactly one frame.
    @(posedge clk_sys); #1;
    din    = 8'h55;
    din_we = 1'b1;
    @(posedge clk_sys); #1;
    din_we = 1'b0;
    @(negedge clk_sys);
    check("single pre-start tx", {31'h0, tx}, 32'h1);
    check("single pre-start empty", {31'h0, empty}, 32'h0);
    @(negedge clk_sys);
    check("single start tx", {31'h0, tx}, 32'h0);
    check("single start busy", {31'h0, busy}, 32'h1);
    check("single popped empty", {31'h0, empty}, 32'h1);
    n = 0;
    while (busy === 1'b1 && n < 2 * FRAME_CYC) begin
      @(negedge clk_sys);
      n++;
    end
    check("single busy length", 32'(n), 32'(FRAME_CYC));
    get_frame("single", 8'h55, 1'b0, s0);
    wait_idle("single");

    // Table of bytes with hand-computed parity.
    for (int i = 0; i < 8; i++) begin
      q = {};
      q.push_back(vecs[i].data);
      write_bytes(q);
      get_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, s0);
      wait_idle($sformatf("vec%0d", i));
    end

    // Back-to-back frames with no idle gap.
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    write_bytes(q);
    get_frame("b2b first", 8'hA5, 1'b0, s0);
    get_frame("b2b second", 8'h3C, 1'b0, s1);
    check("b2b start spacing", 32'(s1 - s0), 32'(FRAME_CYC));
    check("b2b empty after", {31'h0, empty}, 32'h1);
    wait_idle("b2b");

    // Overflow while the line is busy: five accepted, sixth dropped.
    ovf0 = ovf_cnt;
    ov_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_sys); #1;
      din    = ov_bytes[i];
      din_we = 1'b1;
      if (i == 5) begin
        @(negedge clk_sys);
        check("ovf full before 6th", {31'h0, full}, 32'h1);
        check("ovf no pulse yet", {31'h0, overflow}, 32'h0);
      end
    end
    @(posedge clk_sys); #1;
    din_we = 1'b0;
    @(negedge clk_sys);
    check("ovf pulse", {31'h0, overflow}, 32'h1);
    check("ovf still full", {31'h0, full}, 32'h1);
    @(negedge clk_sys);
    check("ovf pulse ends", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 5; i++)
      get_frame($sformatf("ovf frame%0d", i), ov_bytes[i], ^ov_bytes[i], s0);
    repeat (2 * FRAME_CYC) @(negedge clk_sys);
    check("ovf exactly five frames", 32'(rx_q.size()), 32'h0);
    check("ovf pulse count", 32'(ovf_cnt - ovf0), 32'h1);
    wait_idle("ovf");

    // Reset in data bit 3 of 0xFF with two bytes queued.
    q = {};
    q.push_back(8'hFF);
    q.push_back(8'h12);
    q.push_back(8'h34);
    write_bytes(q);
    n = 0;
    while (tx !== 1'b0 && n < FRAME_CYC) begin
      @(negedge clk_sys);
      n++;
    end
    check("rst frame started", {31'h0, tx}, 32'h0);
    s0 = cyc;
    while (cyc - s0 < 4 * DIV + DIV / 2) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst tx", {31'h0, tx}, 32'h1);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst empty", {31'h0, empty}, 32'h1);
    check("rst full", {31'h0, full}, 32'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge clk_sys);
      if (tx !== 1'b1) lows++;
    end
    check("rst line stays idle", 32'(lows), 32'h0);
    check("rst one partial frame", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      check("rst partial aborted", {31'h0, r.aborted}, 32'h1);
    end
    rx_q = {};

    // Random bursts against a queue model: accepted bytes come out in order, back to back.
    ovf0 = ovf_cnt;
    for (int b = 0; b < 6; b++) begin
      q = {};
      n = int'($urandom_range(1, DEPTH + 1));
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        model.push_back(q[i]);
      end
      write_bytes(q);
      for (int i = 0; i < n; i++) begin
        s1 = s0;
        get_frame($sformatf("rand b%0d.%0d", b, i), model[0], ^model[0], s0);
        void'(model.pop_front());
        if (i > 0) check($sformatf("rand spacing b%0d.%0d", b, i), 32'(s0 - s1), 32'(FRAME_CYC));
      end
      wait_idle($sformatf("rand b%0d", b));
    end
    check("rand no overflow", 32'(ovf_cnt - ovf0), 32'h0);
    check("rand no extra frames", 32'(rx_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
